// File: rtl/fir_sample_feeder_if.sv
// Sample handshake and Avalon-ST source bundle for the FIR sample feeder.
// master = feeder side, slave = producer/FIR environment side.
interface fir_sample_feeder_if #(
    parameter int DATA_W = 24
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] ast_sink_data;
    logic              ast_sink_valid;
    logic [1:0]        ast_sink_error;

    modport master (
        input  in_data, in_valid,
        output in_ready, ast_sink_data, ast_sink_valid, ast_sink_error
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, ast_sink_data, ast_sink_valid, ast_sink_error
    );
endinterface

// File: rtl/fir_sample_feeder.sv
// Buffers upstream samples in a small FIFO and issues one sample per rate tick
// to the FIR sink, substituting a muted sample (error 01) when the FIFO is empty.
module fir_sample_feeder #(
    parameter int DATA_W     = 24,
    parameter int DIV        = 1250,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    fir_sample_feeder_if.master   bus,
    output logic [ADDR_W:0]       fifo_level,
    output logic [15:0]           underflow_cnt
);
    localparam int                CNT_W         = $clog2(DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST      = CNT_W'(DIV - 1);
    localparam logic [ADDR_W:0]   LVL_FULL      = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   LVL_EMPTY     = {(ADDR_W + 1){1'b0}};
    localparam logic [1:0]        ERR_GOOD      = 2'b00;
    localparam logic [1:0]        ERR_UNDERFLOW = 2'b01;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [1:0]        err_q, err_d;
    logic [15:0]       ucnt_q, ucnt_d;
    logic              tick_s, push_s, pop_s;

    // Tick generation, FIFO bookkeeping and next output values.
    always_comb begin
        tick_s     = enable && (cnt_q == CNT_LAST);
        push_s     = bus.in_valid && in_ready_q;
        pop_s      = tick_s && (level_q != LVL_EMPTY);

        if (!enable || tick_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end

        wr_ptr_d = push_s ? wr_ptr_q + ADDR_W'(1'b1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + ADDR_W'(1'b1) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + (ADDR_W + 1)'(1'b1);
            2'b01:   level_d = level_q - (ADDR_W + 1)'(1'b1);
            default: level_d = level_q;
        endcase
        in_ready_d = (level_d != LVL_FULL);

        // Empty FIFO on a tick is judged before this cycle's push lands.
        valid_d = tick_s;
        data_d  = data_q;
        err_d   = err_q;
        ucnt_d  = ucnt_q;
        if (tick_s) begin
            if (pop_s) begin
                data_d = mem_q[rd_ptr_q];
                err_d  = ERR_GOOD;
            end else begin
                data_d = {DATA_W{1'b0}};
                err_d  = ERR_UNDERFLOW;
                ucnt_d = (ucnt_q == 16'hFFFF) ? ucnt_q : ucnt_q + 16'd1;
            end
        end else begin
            data_d = data_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q      <= {CNT_W{1'b0}};
            wr_ptr_q   <= {ADDR_W{1'b0}};
            rd_ptr_q   <= {ADDR_W{1'b0}};
            level_q    <= LVL_EMPTY;
            in_ready_q <= 1'b0;
            data_q     <= {DATA_W{1'b0}};
            valid_q    <= 1'b0;
            err_q      <= ERR_GOOD;
            ucnt_q     <= 16'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            in_ready_q <= in_ready_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            ucnt_q     <= ucnt_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= bus.in_data;
            end
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.ast_sink_data  = data_q;
    assign bus.ast_sink_valid = valid_q;
    assign bus.ast_sink_error = err_q;
    assign fifo_level         = level_q;
    assign underflow_cnt      = ucnt_q;
endmodule

// File: doc/fir_sample_feeder.md
Name: fir_sample_feeder

Overview:
Avalon-ST source that drives the sink side of the 24-bit FIR filter wrapper at a fixed sample rate.
- Accepts audio samples from an upstream producer over a valid/ready handshake and buffers them in a small FIFO.
- Issues exactly one sample to the filter per sample-rate tick. The nominal rate is 40 kHz, derived from the system clock.
- Substitutes a muted sample and flags an error when the buffer runs dry.

Parameters:
DATA_W, 24, sample width (signed two's complement)
DIV, 1250, clk cycles per sample tick (50 MHz / 40 kHz); must be >= 2
FIFO_DEPTH, 8, buffer entries; power of two, >= 2
ADDR_W, 3, log2(FIFO_DEPTH)

Ports:
clk  input  1  system clock; the only clock
reset_n  input  1  reset, synchronous, active-low
in_data  input  DATA_W  signed sample from upstream
in_valid  input  1  upstream sample valid
in_ready  output  1  feeder can accept a sample this cycle
enable  input  1  1 = generate sample ticks; 0 = halt output stream
ast_sink_data  output  DATA_W  sample to FIR sink
ast_sink_valid  output  1  one-cycle pulse per issued sample
ast_sink_error  output  2  00 = good sample, 01 = underflow (muted sample)
fifo_level  output  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH
underflow_cnt  output  16  count of muted samples, saturating

Behaviour:
Reset (reset_n=0 at a clk edge):
- FIFO flushed; tick counter = 0.
- All outputs are 0: ast_sink_data, ast_sink_valid, ast_sink_error, fifo_level, underflow_cnt, and in_ready.
- Reset has priority over every other event. A reset mid-stream drops any pending pulse, and buffered samples are discarded.
- in_ready goes to 1 on the first edge after reset_n returns to 1.

Input side:
- in_ready = (fifo_level != FIFO_DEPTH), registered.
- A push occurs when in_valid && in_ready; in_data is written at the FIFO tail.
- The feeder never drops a sample. When in_ready=0, the producer holds its data.

Tick counter:
- When enable=1: counts 0..DIV-1 and wraps to 0.
- tick = enable && (count == DIV-1).
- When enable=0: count is forced to 0 and no ticks occur. FIFO contents are retained and input pushes continue.

Output side (evaluated on the tick cycle, using the FIFO state before that cycle's push):
- FIFO non-empty: pop the head. Next cycle: ast_sink_data = head, ast_sink_valid = 1, ast_sink_error = 00.
- FIFO empty: next cycle: ast_sink_data = 0, ast_sink_valid = 1, ast_sink_error = 01. underflow_cnt increments and saturates at 0xFFFF.
- ast_sink_valid is high for exactly one cycle per tick and low otherwise.
- ast_sink_data and ast_sink_error hold their last values between pulses.
- Latency: the pulse appears 1 cycle after the tick. The first pulse after enable rises comes DIV cycles after the first enabled cycle.

Simultaneous events:
- Push and pop in the same cycle with level >= 1: both occur, and level is unchanged.
- Push while empty on a tick cycle: the tick underflows (muted). The pushed sample stays in the FIFO and is issued at the next tick.
- Full and tick in the same cycle: in_ready was already 0, so there is no push. in_ready returns to 1 the cycle after the pop.
- Read and write pointers are ADDR_W bits and wrap modulo FIFO_DEPTH. fifo_level is updated every cycle as level + push - pop.

Sample format:
- Samples pass through bit-exact; no sign manipulation, rounding, or scaling.

Test Plan:
(Bench uses DIV=4, FIFO_DEPTH=4, ADDR_W=2.)
1. Reset: hold reset_n=0 for 3 cycles with in_valid=1, in_data=0x123456, enable=1.
   -> All outputs are 0 and no write occurs (fifo_level=0). in_ready=1 on the first cycle after release.
2. Ordered stream: with enable=0, push 0x000001, 0x7FFFFF, 0x800000; then set enable=1.
   -> ast_sink_valid pulses at cycles 4, 8, 12 after enable rises, with data 0x000001, 0x7FFFFF, 0x800000 in that order.
   -> error=00 on each pulse; fifo_level steps 3→2→1→0.
3. Underflow: FIFO empty, enable=1 for 16 cycles.
   -> 4 pulses, each with data 0x000000 and error 01; underflow_cnt=4.
   -> Preloading underflow_cnt to 0xFFFE and running 3 more ticks ends at 0xFFFF.
4. Full/backpressure: with enable=0, in_valid=1 for 6 cycles using data 1..6.
   -> Samples 1..4 are accepted; fifo_level=4 and in_ready=0 from the cycle after the 4th push.
   -> After enable=1, the first tick pops sample 1, in_ready returns to 1, and sample 5 is accepted.
5. Same-cycle push/pop: level=1 (sample 0xAAAAAA), push 0x555555 on the tick cycle.
   -> Pulse carries 0xAAAAAA and level stays 1. The next tick issues 0x555555.
   -> Separately, a push into an empty FIFO on a tick cycle produces a muted pulse (error 01), and the pushed sample is issued at the next tick.
6. Reset mid-stream: with 3 samples buffered, assert reset_n=0 on the tick cycle.
   -> No pulse occurs; fifo_level=0 and underflow_cnt=0.
   -> After release with enable=1 and no pushes, the first pulse is a muted underflow DIV cycles later.
